// File: rtl/mat_feed_ctrl.sv
// Frame sequencer ahead of the 3x3 window generator: clears it, feeds one frame, pads flush rows.
// Optional frame statistics counter enabled by defining MAT_FEED_STAT_EN.
module mat_feed_ctrl #(
   parameter int         COL_NUM    = 320,
   parameter int         ROW_NUM    = 720,
   parameter int         FLUSH_ROWS = 1,
   parameter logic [7:0] PAD_VAL    = 8'd0,
   parameter int         GAP        = 0
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mat_rst_n,
   output logic [7:0]  rx_data,
   output logic        pi_flag,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [GW-1:0] GAP_V    = GW'(GAP);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [10:0]   COL_LAST = 11'(COL_NUM - 1);
   localparam logic [10:0]   ROW_LAST = 11'(ROW_NUM - 1);
   localparam logic [12:0]   FL_LAST  = 13'(FLUSH_ROWS * COL_NUM - 1);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_FLUSH, S_DONE} state_t;

   state_t        state, nxt;
   logic          clr_cnt;
   logic          clear_n;
   logic [10:0]   col_cnt, row_cnt;
   logic [12:0]   flush_cnt;
   logic [GW-1:0] gap_cnt;
   logic          xfer, flush_issue;

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt         = state;
      in_ready    = 1'b0;
      frame_done  = 1'b0;
      xfer        = 1'b0;
      flush_issue = 1'b0;
      case (state)
         S_IDLE:  if (start) nxt = S_CLR;
         S_CLR:   if (clr_cnt) nxt = S_FEED;
         S_FEED: begin
            in_ready = (gap_cnt == '0);
            xfer     = in_valid & in_ready;
            if (xfer && col_cnt == COL_LAST && row_cnt == ROW_LAST)
               nxt = (FLUSH_ROWS > 0) ? S_FLUSH : S_DONE;
         end
         S_FLUSH: begin
            flush_issue = (gap_cnt == '0);
            if (flush_issue && flush_cnt == FL_LAST) nxt = S_DONE;
         end
         S_DONE: begin
            frame_done = 1'b1;
            nxt        = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign mat_rst_n = rst_n & clear_n;

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt   <= 1'b0;
         clear_n   <= 1'b1;
         col_cnt   <= '0;
         row_cnt   <= '0;
         flush_cnt <= '0;
         gap_cnt   <= '0;
         rx_data   <= '0;
         pi_flag   <= 1'b0;
      end else begin
         // clear_n tracks the CLR state exactly, so the generator sees two low cycles
         clear_n <= (nxt != S_CLR);
         clr_cnt <= (state == S_CLR) ? ~clr_cnt : 1'b0;
         pi_flag <= xfer | flush_issue;
         if (xfer)             rx_data <= in_data;
         else if (flush_issue) rx_data <= PAD_VAL;

         if (state == S_DONE)          gap_cnt <= '0;
         else if (xfer | flush_issue)  gap_cnt <= GAP_V;
         else if (gap_cnt != '0)       gap_cnt <= gap_cnt - GAP_ONE;

         if (state == S_DONE) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            flush_cnt <= '0;
         end else begin
            if (xfer) begin
               if (col_cnt == COL_LAST) begin
                  col_cnt <= '0;
                  row_cnt <= row_cnt + 11'd1;
               end else begin
                  col_cnt <= col_cnt + 11'd1;
               end
            end
            if (flush_issue) flush_cnt <= flush_cnt + 13'd1;
         end
      end
   end

`ifdef MAT_FEED_STAT_EN
   logic [15:0] fcnt;
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n)          fcnt <= '0;
      else if (frame_done) fcnt <= fcnt + 16'd1;
   end
   assign frame_cnt = fcnt;
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mat_feed_ctrl.sv
// Directed bench for mat_feed_ctrl: scoreboard on pi_flag/rx_data, GAP=0 and GAP=2 instances.
module tb_mat_feed_ctrl;

   localparam int         COL  = 4;
   localparam int         ROW  = 3;
   localparam int         FR   = 1;
   localparam int         NPIX = COL * ROW;
   localparam int         NTOT = COL * (ROW + FR);
   localparam logic [7:0] PAD  = 8'd0;

   logic        sclk = 1'b0, rst_n = 1'b0;
   logic        start0 = 1'b0, start2 = 1'b0, in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        rdy0, mrst0, pi0, busy0, done0;
   logic        rdy2, mrst2, pi2, busy2, done2;
   logic [7:0]  rx0, rx2;
   logic [15:0] fcnt0, fcnt2;

   int checks = 0, errors = 0;

   always #5 sclk = ~sclk;

   mat_feed_ctrl #(.COL_NUM(COL), .ROW_NUM(ROW), .FLUSH_ROWS(FR), .PAD_VAL(PAD), .GAP(0)) u_dut (
      .sclk(sclk), .rst_n(rst_n), .start(start0), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .mat_rst_n(mrst0), .rx_data(rx0), .pi_flag(pi0), .busy(busy0),
      .frame_done(done0), .frame_cnt(fcnt0));

   mat_feed_ctrl #(.COL_NUM(COL), .ROW_NUM(ROW), .FLUSH_ROWS(FR), .PAD_VAL(PAD), .GAP(2)) u_gap (
      .sclk(sclk), .rst_n(rst_n), .start(start2), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy2), .mat_rst_n(mrst2), .rx_data(rx2), .pi_flag(pi2), .busy(busy2),
      .frame_done(done2), .frame_cnt(fcnt2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the GAP=0 instance: accepted pixels, then flush pads, in issue order
   logic [7:0] sb[$];
   int  acc = 0, pulses = 0, dones = 0, mlow = 0;
   bit  hs_d = 1'b0, done_d = 1'b0;

   always @(negedge sclk) begin
      if (!rst_n) begin
         sb.delete();
         acc = 0; pulses = 0; mlow = 0; hs_d = 1'b0; done_d = 1'b0;
      end else begin
         if (hs_d) chk("pi_latency", 32'(pi0), 32'd1);
         if (pi0) begin
            logic [31:0] e;
            e = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'h100;
            chk("rx_data", 32'(rx0), e);
            pulses++;
         end
         if (!mrst0) mlow++;
         if (done_d) chk("busy_fall", 32'(busy0), 32'd0);
         done_d = done0;
         if (done0) begin
            dones++;
            chk("busy_at_done", 32'(busy0), 32'd1);
            chk("pulse_count", 32'(pulses), 32'(NTOT));
            chk("clr_cycles", 32'(mlow), 32'd2);
            chk("sb_drained", 32'(sb.size()), 32'd0);
            pulses = 0; mlow = 0; acc = 0;
         end
         hs_d = in_valid & rdy0;
         if (hs_d) begin
            sb.push_back(in_data);
            acc++;
            if (acc == NPIX) repeat (COL * FR) sb.push_back(PAD);
         end
      end
   end

   // GAP=2 instance: spacing, ready blocking, data order
   int gpulses = 0, gsince = 0;
   bit gprev = 1'b0;

   always @(negedge sclk) begin
      if (!rst_n) begin
         gpulses = 0; gsince = 0; gprev = 1'b0;
      end else begin
         gsince++;
         if (gprev) chk("gap_ready_low2", 32'(rdy2), 32'd0);
         if (pi2) begin
            if (gpulses > 0) chk("gap_spacing", 32'(gsince), 32'd3);
            chk("gap_rx", 32'(rx2), (gpulses < NPIX) ? 32'(gpulses + 1) : 32'(PAD));
            chk("gap_ready_low", 32'(rdy2), 32'd0);
            gpulses++;
            gsince = 0;
         end
         gprev = pi2;
         if (done2) begin
            chk("gap_pulses", 32'(gpulses), 32'(NTOT));
            gpulses = 0;
         end
      end
   end

   task automatic run_frame(input bit sel, input bit rnd, input int abort_at);
      int  v = 1;
      int  budget = 0;
      bit  seen = 1'b0;
      @(posedge sclk); #1;
      if (sel) start2 = 1'b1; else start0 = 1'b1;
      @(posedge sclk); #1;
      start0 = 1'b0; start2 = 1'b0;
      while (v <= NPIX && budget < 500) begin
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = 8'(v);
         start0   = (rnd && v == 6);
         @(negedge sclk);
         if (in_valid && (sel ? rdy2 : rdy0)) v++;
         @(posedge sclk); #1;
         budget++;
         if (abort_at > 0 && v > abort_at) break;
      end
      in_valid = 1'b0;
      start0   = 1'b0;
      if (abort_at > 0) return;
      chk("feed_timeout", 32'(v), 32'(NPIX + 1));
      budget = 0;
      while (!seen && budget < 200) begin
         @(negedge sclk);
         seen = sel ? done2 : done0;
         budget++;
      end
      chk("done_timeout", 32'(seen), 32'd1);
      @(negedge sclk);
   endtask

   initial begin
      // 1: reset state
      repeat (5) @(posedge sclk);
      @(negedge sclk);
      chk("rst_ready", 32'(rdy0), 32'd0);
      chk("rst_pi", 32'(pi0), 32'd0);
      chk("rst_rx", 32'(rx0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_fcnt", 32'(fcnt0), 32'd0);
      chk("rst_mrst", 32'(mrst0), 32'd0);
      @(posedge sclk); #1;
      rst_n = 1'b1;
      @(negedge sclk);
      chk("rel_mrst", 32'(mrst0), 32'd1);
      chk("rel_busy", 32'(busy0), 32'd0);

      // 5: abort after sixth pixel, then clean frame
      run_frame(1'b0, 1'b0, 6);
      rst_n = 1'b0;
      repeat (2) @(negedge sclk);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_pi", 32'(pi0), 32'd0);
      chk("abort_mrst", 32'(mrst0), 32'd0);
      chk("abort_no_done", 32'(dones), 32'd0);
      @(posedge sclk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge sclk);
      chk("abort_idle", 32'(busy0), 32'd0);

      // 2: clean frame, continuous valid
      run_frame(1'b0, 1'b0, 0);
`ifdef MAT_FEED_STAT_EN
      chk("fcnt_1", 32'(fcnt0), 32'd1);
`else
      chk("fcnt_1", 32'(fcnt0), 32'd0);
`endif

      // 4: random valid with a stray start mid-FEED
      run_frame(1'b0, 1'b1, 0);
`ifdef MAT_FEED_STAT_EN
      chk("fcnt_2", 32'(fcnt0), 32'd2);
`else
      chk("fcnt_2", 32'(fcnt0), 32'd0);
`endif

      // 6: third frame
      run_frame(1'b0, 1'b0, 0);
`ifdef MAT_FEED_STAT_EN
      chk("fcnt_3", 32'(fcnt0), 32'd3);
`else
      chk("fcnt_3", 32'(fcnt0), 32'd0);
`endif
      chk("frames_done", 32'(dones), 32'd3);
      chk("idle_after", 32'(busy0), 32'd0);

      // 3: GAP=2 instance, valid held high
      run_frame(1'b1, 1'b0, 0);
      chk("gap_idle", 32'(busy2), 32'd0);
      chk("gap_mrst", 32'(mrst2), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
